sdram_arbiter: RTL and testbench

Shares the single-port SDRAM controller (`sdram`, 23-bit word address, 32-bit data, req/ack/valid handshake) between the ROM download write path and several game-side ROM read requesters: program, character, foreground, background and sprite. It sits between `rygar` and `sdram`.

- Download writes have absolute priority.
- Read ports are served round-robin.
- Each read port has a one-entry address/data cache, so a repeated read of the same address does not touch SDRAM.

---
 rtl/sdram_arbiter_pkg.sv | 19 +
 rtl/rr_select.sv | 27 ++
 rtl/sdram_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_sdram_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_arbiter_pkg.sv
// Shared types for the SDRAM arbiter.
// Download owner is encoded one past the last read port.
package sdram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_ACK,
    WAIT_VALID
  } arb_state_t;

  localparam int OWNER_W = 4;
  localparam int NUM_PORTS_DEF = 4;
  localparam logic [OWNER_W-1:0] OWNER_DL = OWNER_W'(NUM_PORTS_DEF);

  function automatic logic [OWNER_W-1:0] owner_dl(input int n);
    return OWNER_W'(n);
  endfunction

endpackage

// File: rtl/rr_select.sv
// Combinational round-robin picker.
// Returns the first set request at or after ptr.
module rr_select #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          grant_valid,
  output logic [IW-1:0] grant_idx
);

  always_comb begin
    int j;
    grant_valid = 1'b0;
    grant_idx   = '0;
    j           = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!grant_valid && req[j]) begin
        grant_valid = 1'b1;
        grant_idx   = IW'(j);
      end
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// Shares one SDRAM controller between the ROM download writer
// and round-robin read ports, each with a one-entry cache.
module sdram_arbiter
  import sdram_arbiter_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_WIDTH = 23,
  parameter int DATA_WIDTH = 32
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_WIDTH-1:0]           dl_addr,
  input  logic [DATA_WIDTH-1:0]           dl_data,
  input  logic                            dl_req,
  output logic                            dl_ack,
  input  logic [NUM_PORTS*ADDR_WIDTH-1:0] port_addr,
  input  logic [NUM_PORTS-1:0]            port_req,
  output logic [NUM_PORTS*DATA_WIDTH-1:0] port_data,
  output logic [NUM_PORTS-1:0]            port_valid,
  output logic [ADDR_WIDTH-1:0]           sdram_addr,
  output logic [DATA_WIDTH-1:0]           sdram_data,
  output logic                            sdram_we,
  output logic                            sdram_req,
  input  logic                            sdram_ack,
  input  logic                            sdram_valid,
  input  logic [DATA_WIDTH-1:0]           sdram_q
);

  localparam int IW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [OWNER_W-1:0] OWN_DL = owner_dl(NUM_PORTS);

  arb_state_t state_q, state_d;

  logic [IW-1:0]         rr_q;
  logic [IW-1:0]         rr_nxt;
  logic [IW-1:0]         gidx;
  logic                  gv;
  logic [OWNER_W-1:0]    owner_q;
  logic [ADDR_WIDTH-1:0] paddr [NUM_PORTS];
  logic [ADDR_WIDTH-1:0] cache_addr_q [NUM_PORTS];
  logic [DATA_WIDTH-1:0] pdata_q [NUM_PORTS];
  logic [NUM_PORTS-1:0]  cache_ok_q;
  logic [NUM_PORTS-1:0]  match;
  logic [NUM_PORTS-1:0]  hit;
  logic [NUM_PORTS-1:0]  cand;
  logic [NUM_PORTS-1:0]  fill_vec;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic                  issue_dl;
  logic                  issue_rd;
  logic                  ack_done;
  logic                  fill;
  logic                  dl_done;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign paddr[g] = port_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign port_data[g*DATA_WIDTH +: DATA_WIDTH] = pdata_q[g];
  end

  // A port is masked for one cycle after its valid pulse so a
  // still-held request cannot re-trigger before the requester moves on.
  always_comb begin
    match    = '0;
    hit      = '0;
    cand     = '0;
    fill_vec = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      match[i] = cache_ok_q[i] && (paddr[i] == cache_addr_q[i]);
      hit[i]   = port_req[i] && match[i] && !port_valid[i] &&
                 !(state_q != IDLE && owner_q == OWNER_W'(i));
      cand[i]  = port_req[i] && !match[i] && !port_valid[i];
      fill_vec[i] = fill && (owner_q == OWNER_W'(i));
    end
  end

  rr_select #(
    .N  (NUM_PORTS),
    .IW (IW)
  ) u_rr (
    .req         (cand),
    .ptr         (rr_q),
    .grant_valid (gv),
    .grant_idx   (gidx)
  );

  always_comb begin
    grant_addr = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gidx == IW'(i)) grant_addr = paddr[i];
    end
    rr_nxt = (int'(gidx) == NUM_PORTS - 1) ? '0 : gidx + 1'b1;
  end

  assign dl_done = ack_done && (owner_q == OWN_DL);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    issue_dl = 1'b0;
    issue_rd = 1'b0;
    ack_done = 1'b0;
    fill     = 1'b0;
    unique case (state_q)
      IDLE: begin
        // dl_req is still high during the dl_ack cycle
        if (dl_req && !dl_ack) begin
          issue_dl = 1'b1;
          state_d  = WAIT_ACK;
        end else if (gv) begin
          issue_rd = 1'b1;
          state_d  = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (sdram_ack) begin
          ack_done = 1'b1;
          state_d  = (owner_q == OWN_DL) ? IDLE : WAIT_VALID;
        end
      end
      WAIT_VALID: begin
        if (sdram_valid) begin
          fill    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_q       <= '0;
      owner_q    <= '0;
      sdram_addr <= '0;
      sdram_data <= '0;
      sdram_we   <= 1'b0;
      sdram_req  <= 1'b0;
      dl_ack     <= 1'b0;
      port_valid <= '0;
      cache_ok_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        pdata_q[i]      <= '0;
        cache_addr_q[i] <= '0;
      end
    end else begin
      dl_ack     <= dl_done;
      port_valid <= hit | fill_vec;
      if (issue_dl) begin
        sdram_addr <= dl_addr;
        sdram_data <= dl_data;
        sdram_we   <= 1'b1;
        sdram_req  <= 1'b1;
        owner_q    <= OWN_DL;
      end else if (issue_rd) begin
        sdram_addr <= grant_addr;
        sdram_data <= '0;
        sdram_we   <= 1'b0;
        sdram_req  <= 1'b1;
        owner_q    <= OWNER_W'(gidx);
        rr_q       <= rr_nxt;
      end else if (ack_done) begin
        sdram_req <= 1'b0;
      end
      if (dl_done) begin
        cache_ok_q <= '0;
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (fill_vec[i]) begin
          pdata_q[i]      <= sdram_q;
          cache_addr_q[i] <= sdram_addr;
          cache_ok_q[i]   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter; the bench plays the SDRAM
// controller and the requesters, all driven on the falling edge.
module tb_sdram_arbiter;

  localparam int NP = 4;
  localparam int AW = 23;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            reset;
  logic [AW-1:0]   dl_addr;
  logic [DW-1:0]   dl_data;
  logic            dl_req;
  logic            dl_ack;
  logic [NP*AW-1:0] port_addr;
  logic [NP-1:0]   port_req;
  logic [NP*DW-1:0] port_data;
  logic [NP-1:0]   port_valid;
  logic [AW-1:0]   sdram_addr;
  logic [DW-1:0]   sdram_data;
  logic            sdram_we;
  logic            sdram_req;
  logic            sdram_ack;
  logic            sdram_valid;
  logic [DW-1:0]   sdram_q;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  sdram_arbiter #(
    .NUM_PORTS  (NP),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .dl_addr     (dl_addr),
    .dl_data     (dl_data),
    .dl_req      (dl_req),
    .dl_ack      (dl_ack),
    .port_addr   (port_addr),
    .port_req    (port_req),
    .port_data   (port_data),
    .port_valid  (port_valid),
    .sdram_addr  (sdram_addr),
    .sdram_data  (sdram_data),
    .sdram_we    (sdram_we),
    .sdram_req   (sdram_req),
    .sdram_ack   (sdram_ack),
    .sdram_valid (sdram_valid),
    .sdram_q     (sdram_q)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, got, exp);
  endtask

  function automatic logic [DW-1:0] model_q(input logic [AW-1:0] a);
    if (a == 23'h1234) return 32'hDEAD_BEEF;
    return {9'h0, a} ^ 32'hC0DE_0000;
  endfunction

  function automatic logic [DW-1:0] pd(input int p);
    return port_data[p*DW +: DW];
  endfunction

  task automatic set_addr(input int p, input logic [AW-1:0] a);
    port_addr[p*AW +: AW] = a;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!sdram_req && n < 20) begin
      tick();
      n++;
    end
    chk("req_wait", sdram_req, 1);
  endtask

  // Acks one cycle after req seen, returns data the cycle after
  task automatic serve_read(input int p, input logic [AW-1:0] a);
    logic [DW-1:0] q;
    wait_req();
    chk("rd_addr", sdram_addr, a);
    chk("rd_we", sdram_we, 0);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    chk("rd_req_drop", sdram_req, 0);
    q = model_q(a);
    sdram_valid = 1'b1;
    sdram_q     = q;
    tick();
    sdram_valid = 1'b0;
    chk("rd_valid", port_valid, 64'(1 << p));
    chk("rd_data", pd(p), q);
  endtask

  initial begin
    logic [AW-1:0] a;
    int p;
    reset       = 1'b1;
    dl_addr     = '0;
    dl_data     = '0;
    dl_req      = 1'b0;
    port_addr   = '0;
    port_req    = '0;
    sdram_ack   = 1'b0;
    sdram_valid = 1'b0;
    sdram_q     = '0;
    tick();
    tick();
    chk("rst_req", sdram_req, 0);
    chk("rst_we", sdram_we, 0);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_dl_ack", dl_ack, 0);
    chk("rst_pv", port_valid, 0);
    chk("rst_pd", port_data, 0);
    reset = 1'b0;

    // download beats four pending reads
    dl_addr  = 23'h100;
    dl_data  = 32'h55AA_1234;
    dl_req   = 1'b1;
    for (int i = 0; i < NP; i++) set_addr(i, AW'(23'h10 + i));
    port_req = 4'b1111;
    tick();
    chk("dl_req", sdram_req, 1);
    chk("dl_we", sdram_we, 1);
    chk("dl_addr", sdram_addr, 23'h100);
    chk("dl_data", sdram_data, 32'h55AA_1234);
    tick();
    chk("dl_hold", sdram_req, 1);
    sdram_ack = 1'b1;
    chk("dl_ack_early", dl_ack, 0);
    tick();
    sdram_ack = 1'b0;
    chk("dl_ack", dl_ack, 1);
    chk("dl_req_drop", sdram_req, 0);
    dl_req = 1'b0;

    // round robin 0,1,2,3,0 with moving addresses
    for (int k = 0; k < 5; k++) begin
      p = k % NP;
      a = (k < NP) ? AW'(23'h10 + p) : 23'h110;
      serve_read(p, a);
      set_addr(p, a + 23'h100);
    end
    port_req = '0;
    tick();
    tick();

    // cache hit on port 2
    set_addr(2, 23'h1234);
    port_req = 4'b0100;
    serve_read(2, 23'h1234);
    port_req = '0;
    tick();
    port_req = 4'b0100;
    tick();
    chk("hit_pv", port_valid, 4'b0100);
    chk("hit_data", pd(2), 32'hDEAD_BEEF);
    chk("hit_noreq", sdram_req, 0);
    port_req = '0;
    tick();
    chk("hit_quiet", sdram_req, 0);

    // download invalidates, re-read goes to SDRAM
    dl_addr = 23'h7;
    dl_data = 32'h1;
    dl_req  = 1'b1;
    wait_req();
    chk("inv_we", sdram_we, 1);
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    chk("inv_dl_ack", dl_ack, 1);
    dl_req   = 1'b0;
    port_req = 4'b0100;
    tick();
    chk("inv_reread", sdram_req, 1);
    chk("inv_no_hit", port_valid, 0);
    serve_read(2, 23'h1234);
    port_req = '0;
    tick();

    // port 0 fill and port 1 hit in the same cycle
    set_addr(1, 23'h40);
    port_req = 4'b0010;
    serve_read(1, 23'h40);
    port_req = '0;
    tick();
    set_addr(0, 23'h50);
    port_req = 4'b0001;
    wait_req();
    chk("cc_addr", sdram_addr, 23'h50);
    sdram_ack = 1'b1;
    tick();
    sdram_ack   = 1'b0;
    sdram_valid = 1'b1;
    sdram_q     = model_q(23'h50);
    port_req    = 4'b0011;
    tick();
    sdram_valid = 1'b0;
    chk("cc_pv", port_valid, 4'b0011);
    chk("cc_d0", pd(0), model_q(23'h50));
    chk("cc_d1", pd(1), model_q(23'h40));
    port_req = '0;
    tick();

    // reset while waiting for read data
    set_addr(3, 23'h60);
    port_req = 4'b1000;
    wait_req();
    sdram_ack = 1'b1;
    tick();
    sdram_ack = 1'b0;
    reset     = 1'b1;
    #1;
    chk("rr_req", sdram_req, 0);
    chk("rr_addr", sdram_addr, 0);
    chk("rr_pd", port_data, 0);
    port_req = '0;
    tick();
    reset       = 1'b0;
    sdram_valid = 1'b1;
    sdram_q     = 32'hBAD0_BAD0;
    tick();
    sdram_valid = 1'b0;
    chk("rr_late_pv", port_valid, 0);
    chk("rr_late_pd", pd(3), 0);
    port_req = 4'b1000;
    serve_read(3, 23'h60);
    port_req = '0;
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
